// File: rtl/aes_sub_bytes_seq.sv
// Sequential forward AES SubBytes: substitutes a 128-bit state LANES bytes per clock.
// Optional output ShiftRows wiring is enabled by defining AES_SHIFT_ROWS_EN.
module aes_sub_bytes_seq #(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    localparam int         N    = 16 / LANES;
    localparam logic [3:0] LAST = 4'(N - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_lanes_check
        $error("aes_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
    end

    logic [1:0] state;
    logic [3:0] cnt;
    logic [7:0] buffer   [16];
    logic [3:0] lane_idx [LANES];
    logic [7:0] lane_out [LANES];

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] s;
        s = 8'h00;
        case (x)
            8'h00: s = 8'h63; 8'h01: s = 8'h7c; 8'h02: s = 8'h77; 8'h03: s = 8'h7b; 8'h04: s = 8'hf2; 8'h05: s = 8'h6b; 8'h06: s = 8'h6f; 8'h07: s = 8'hc5;
            8'h08: s = 8'h30; 8'h09: s = 8'h01; 8'h0a: s = 8'h67; 8'h0b: s = 8'h2b; 8'h0c: s = 8'hfe; 8'h0d: s = 8'hd7; 8'h0e: s = 8'hab; 8'h0f: s = 8'h76;
            8'h10: s = 8'hca; 8'h11: s = 8'h82; 8'h12: s = 8'hc9; 8'h13: s = 8'h7d; 8'h14: s = 8'hfa; 8'h15: s = 8'h59; 8'h16: s = 8'h47; 8'h17: s = 8'hf0;
            8'h18: s = 8'had; 8'h19: s = 8'hd4; 8'h1a: s = 8'ha2; 8'h1b: s = 8'haf; 8'h1c: s = 8'h9c; 8'h1d: s = 8'ha4; 8'h1e: s = 8'h72; 8'h1f: s = 8'hc0;
            8'h20: s = 8'hb7; 8'h21: s = 8'hfd; 8'h22: s = 8'h93; 8'h23: s = 8'h26; 8'h24: s = 8'h36; 8'h25: s = 8'h3f; 8'h26: s = 8'hf7; 8'h27: s = 8'hcc;
            8'h28: s = 8'h34; 8'h29: s = 8'ha5; 8'h2a: s = 8'he5; 8'h2b: s = 8'hf1; 8'h2c: s = 8'h71; 8'h2d: s = 8'hd8; 8'h2e: s = 8'h31; 8'h2f: s = 8'h15;
            8'h30: s = 8'h04; 8'h31: s = 8'hc7; 8'h32: s = 8'h23; 8'h33: s = 8'hc3; 8'h34: s = 8'h18; 8'h35: s = 8'h96; 8'h36: s = 8'h05; 8'h37: s = 8'h9a;
            8'h38: s = 8'h07; 8'h39: s = 8'h12; 8'h3a: s = 8'h80; 8'h3b: s = 8'he2; 8'h3c: s = 8'heb; 8'h3d: s = 8'h27; 8'h3e: s = 8'hb2; 8'h3f: s = 8'h75;
            8'h40: s = 8'h09; 8'h41: s = 8'h83; 8'h42: s = 8'h2c; 8'h43: s = 8'h1a; 8'h44: s = 8'h1b; 8'h45: s = 8'h6e; 8'h46: s = 8'h5a; 8'h47: s = 8'ha0;
            8'h48: s = 8'h52; 8'h49: s = 8'h3b; 8'h4a: s = 8'hd6; 8'h4b: s = 8'hb3; 8'h4c: s = 8'h29; 8'h4d: s = 8'he3; 8'h4e: s = 8'h2f; 8'h4f: s = 8'h84;
            8'h50: s = 8'h53; 8'h51: s = 8'hd1; 8'h52: s = 8'h00; 8'h53: s = 8'hed; 8'h54: s = 8'h20; 8'h55: s = 8'hfc; 8'h56: s = 8'hb1; 8'h57: s = 8'h5b;
            8'h58: s = 8'h6a; 8'h59: s = 8'hcb; 8'h5a: s = 8'hbe; 8'h5b: s = 8'h39; 8'h5c: s = 8'h4a; 8'h5d: s = 8'h4c; 8'h5e: s = 8'h58; 8'h5f: s = 8'hcf;
            8'h60: s = 8'hd0; 8'h61: s = 8'hef; 8'h62: s = 8'haa; 8'h63: s = 8'hfb; 8'h64: s = 8'h43; 8'h65: s = 8'h4d; 8'h66: s = 8'h33; 8'h67: s = 8'h85;
            8'h68: s = 8'h45; 8'h69: s = 8'hf9; 8'h6a: s = 8'h02; 8'h6b: s = 8'h7f; 8'h6c: s = 8'h50; 8'h6d: s = 8'h3c; 8'h6e: s = 8'h9f; 8'h6f: s = 8'ha8;
            8'h70: s = 8'h51; 8'h71: s = 8'ha3; 8'h72: s = 8'h40; 8'h73: s = 8'h8f; 8'h74: s = 8'h92; 8'h75: s = 8'h9d; 8'h76: s = 8'h38; 8'h77: s = 8'hf5;
            8'h78: s = 8'hbc; 8'h79: s = 8'hb6; 8'h7a: s = 8'hda; 8'h7b: s = 8'h21; 8'h7c: s = 8'h10; 8'h7d: s = 8'hff; 8'h7e: s = 8'hf3; 8'h7f: s = 8'hd2;
            8'h80: s = 8'hcd; 8'h81: s = 8'h0c; 8'h82: s = 8'h13; 8'h83: s = 8'hec; 8'h84: s = 8'h5f; 8'h85: s = 8'h97; 8'h86: s = 8'h44; 8'h87: s = 8'h17;
            8'h88: s = 8'hc4; 8'h89: s = 8'ha7; 8'h8a: s = 8'h7e; 8'h8b: s = 8'h3d; 8'h8c: s = 8'h64; 8'h8d: s = 8'h5d; 8'h8e: s = 8'h19; 8'h8f: s = 8'h73;
            8'h90: s = 8'h60; 8'h91: s = 8'h81; 8'h92: s = 8'h4f; 8'h93: s = 8'hdc; 8'h94: s = 8'h22; 8'h95: s = 8'h2a; 8'h96: s = 8'h90; 8'h97: s = 8'h88;
            8'h98: s = 8'h46; 8'h99: s = 8'hee; 8'h9a: s = 8'hb8; 8'h9b: s = 8'h14; 8'h9c: s = 8'hde; 8'h9d: s = 8'h5e; 8'h9e: s = 8'h0b; 8'h9f: s = 8'hdb;
            8'ha0: s = 8'he0; 8'ha1: s = 8'h32; 8'ha2: s = 8'h3a; 8'ha3: s = 8'h0a; 8'ha4: s = 8'h49; 8'ha5: s = 8'h06; 8'ha6: s = 8'h24; 8'ha7: s = 8'h5c;
            8'ha8: s = 8'hc2; 8'ha9: s = 8'hd3; 8'haa: s = 8'hac; 8'hab: s = 8'h62; 8'hac: s = 8'h91; 8'had: s = 8'h95; 8'hae: s = 8'he4; 8'haf: s = 8'h79;
            8'hb0: s = 8'he7; 8'hb1: s = 8'hc8; 8'hb2: s = 8'h37; 8'hb3: s = 8'h6d; 8'hb4: s = 8'h8d; 8'hb5: s = 8'hd5; 8'hb6: s = 8'h4e; 8'hb7: s = 8'ha9;
            8'hb8: s = 8'h6c; 8'hb9: s = 8'h56; 8'hba: s = 8'hf4; 8'hbb: s = 8'hea; 8'hbc: s = 8'h65; 8'hbd: s = 8'h7a; 8'hbe: s = 8'hae; 8'hbf: s = 8'h08;
            8'hc0: s = 8'hba; 8'hc1: s = 8'h78; 8'hc2: s = 8'h25; 8'hc3: s = 8'h2e; 8'hc4: s = 8'h1c; 8'hc5: s = 8'ha6; 8'hc6: s = 8'hb4; 8'hc7: s = 8'hc6;
            8'hc8: s = 8'he8; 8'hc9: s = 8'hdd; 8'hca: s = 8'h74; 8'hcb: s = 8'h1f; 8'hcc: s = 8'h4b; 8'hcd: s = 8'hbd; 8'hce: s = 8'h8b; 8'hcf: s = 8'h8a;
            8'hd0: s = 8'h70; 8'hd1: s = 8'h3e; 8'hd2: s = 8'hb5; 8'hd3: s = 8'h66; 8'hd4: s = 8'h48; 8'hd5: s = 8'h03; 8'hd6: s = 8'hf6; 8'hd7: s = 8'h0e;
            8'hd8: s = 8'h61; 8'hd9: s = 8'h35; 8'hda: s = 8'h57; 8'hdb: s = 8'hb9; 8'hdc: s = 8'h86; 8'hdd: s = 8'hc1; 8'hde: s = 8'h1d; 8'hdf: s = 8'h9e;
            8'he0: s = 8'he1; 8'he1: s = 8'hf8; 8'he2: s = 8'h98; 8'he3: s = 8'h11; 8'he4: s = 8'h69; 8'he5: s = 8'hd9; 8'he6: s = 8'h8e; 8'he7: s = 8'h94;
            8'he8: s = 8'h9b; 8'he9: s = 8'h1e; 8'hea: s = 8'h87; 8'heb: s = 8'he9; 8'hec: s = 8'hce; 8'hed: s = 8'h55; 8'hee: s = 8'h28; 8'hef: s = 8'hdf;
            8'hf0: s = 8'h8c; 8'hf1: s = 8'ha1; 8'hf2: s = 8'h89; 8'hf3: s = 8'h0d; 8'hf4: s = 8'hbf; 8'hf5: s = 8'he6; 8'hf6: s = 8'h42; 8'hf7: s = 8'h68;
            8'hf8: s = 8'h41; 8'hf9: s = 8'h99; 8'hfa: s = 8'h2d; 8'hfb: s = 8'h0f; 8'hfc: s = 8'hb0; 8'hfd: s = 8'h54; 8'hfe: s = 8'hbb; 8'hff: s = 8'h16;
            default: s = 8'h00;
        endcase
        return s;
    endfunction

    // Group cnt covers bytes cnt*LANES .. cnt*LANES+LANES-1; one S-box per lane.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_idx[l] = 4'(int'(cnt) * LANES) + 4'(l);
            lane_out[l] = sbox(buffer[lane_idx[l]]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
            for (int i = 0; i < 16; i++) buffer[i] <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int i = 0; i < 16; i++) buffer[i] <= in_data[127 - 8*i -: 8];
                        cnt   <= 4'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    for (int l = 0; l < LANES; l++) buffer[lane_idx[l]] <= lane_out[l];
                    if (cnt == LAST) begin
                        cnt   <= 4'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                DONE: begin
                    if (out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // in_ready is forced low while reset is held even though the state already reads IDLE.
    assign in_ready  = rst_n && (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state == BUSY) || (state == DONE);

    for (genvar i = 0; i < 16; i++) begin : g_out
`ifdef AES_SHIFT_ROWS_EN
        localparam int R   = i % 4;
        localparam int C   = i / 4;
        localparam int SRC = 4 * ((C + R) % 4) + R;
        assign out_data[127 - 8*i -: 8] = buffer[SRC];
`else
        assign out_data[127 - 8*i -: 8] = buffer[i];
`endif
    end

endmodule

// File: doc/aes_sub_bytes_seq.md
Name: aes_sub_bytes_seq

Overview:
Forward AES SubBytes engine for the encryption datapath. Accepts a 128-bit AES state over a valid/ready handshake and substitutes every byte through the FIPS-197 forward S-box, LANES bytes per clock. It holds the result until the downstream stage accepts it, and sits between AddRoundKey and MixColumns in the encrypt round pipeline.

Parameters:
LANES, 4, bytes substituted per cycle; legal values 1, 2, 4, 8, 16; any other value is an elaboration error (generate-time check).

Ports:
clk  input  1  rising-edge clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  in_data valid.
in_ready  output  1  block can accept a state.
in_data  input  128  input state; byte i = in_data[127-8i -: 8]; FIPS column-major, byte i = row i%4, column i/4.
out_valid  output  1  out_data valid.
out_ready  input  1  downstream accepts out_data.
out_data  output  128  substituted state, same byte order as in_data.
busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (rst_n=0, asynchronous): state=IDLE, byte counter=0, internal 128-bit buffer=0, in_ready=0 while rst_n low, out_valid=0, busy=0, out_data=0. The first cycle after deassertion has in_ready=1.
- N = 16/LANES.
- S-box: internal 256-entry FIPS-197 forward table, combinational lookup with one lookup per lane. Checkpoints: S(00)=63, S(01)=7c, S(53)=ed, S(52)=00, S(ff)=16.
- FSM IDLE/BUSY/DONE, registered state.
- IDLE: in_ready=1, out_valid=0.
  - On in_valid&&in_ready: buffer<=in_data, cnt<=0, go to BUSY.
- BUSY: in_ready=0.
  - Each cycle, buffer bytes [cnt*LANES .. cnt*LANES+LANES-1] <= S(byte), in place.
  - cnt increments each cycle. When cnt==N-1, the final group is written, cnt is cleared, and the FSM goes to DONE.
- DONE: out_valid=1, out_data=buffer (registered, stable while out_valid && !out_ready).
  - On out_ready: go to IDLE. in_ready rises the next cycle, with no same-cycle accept in DONE.
- Latency: acceptance edge E0, then out_valid high after edge E0+N. LANES=16 gives 1 cycle; LANES=1 gives 16 cycles.
- Throughput: one state per N+2 cycles when out_ready is held high.
- in_valid while not IDLE is ignored; no state change; the input is not captured.
- out_ready while out_valid=0 has no effect.
- in_data/in_valid changing in BUSY/DONE has no effect on the in-flight result.
- Reset asserted mid-BUSY or in DONE discards the state; all outputs go to their reset values immediately.
- out_data outside DONE: holds the buffer contents (don't-care for consumers; bench checks only while out_valid=1).
- No X propagation from the table. The case default returns 00 and is unreachable for 8-bit inputs.

Optional Feature:
AES_SHIFT_ROWS_EN.
- Defined: out_data = ShiftRows(buffer), i.e. row r cyclically left-shifted by r columns, pure wiring on the output. Output byte at (row r, col c) = buffer byte at (r, (c+r)%4). Latency and handshake are unchanged.
- Undefined: out_data = buffer (SubBytes only); no extra wiring.

Test Plan:
- Reset/idle: rst_n low 3 cycles, then high -> out_valid=0, busy=0, out_data=0, in_ready=1 the first cycle after release.
- Zero state, LANES=4, out_ready=1: in_data=0 accepted at E0 -> out_valid high after E0+4; out_data=6363...63 (16 bytes); in_ready=1 two cycles after acceptance plus N.
- FIPS-197 App. B, round 1, each LANES in {1,2,4,8,16}: in_data=193de3bea0f4e22b9ac68d2ae9f84808.
  - Without macro -> out_data=d42711aee0bf98f1b8b45de51e415230, out_valid after exactly N cycles.
  - With AES_SHIFT_ROWS_EN -> d4bf5d30e0b452aeb84111f11e2798e5.
- Backpressure: out_ready=0 for 10 cycles in DONE, in_valid=1 with a new state -> out_valid stays 1, out_data unchanged, in_ready=0. Then out_ready=1 for one cycle -> the next state is accepted the following cycle and its result is correct.
- Mid-operation reset: assert rst_n=0 at BUSY cycle 2 of 4 -> outputs zero immediately. Then send in_data=000102...0f -> out_data=637c777bf26b6fc53001672bfed7ab76, with no residue from the aborted state.
- Exhaustive table: 16 states covering bytes 00..ff (state k = bytes 16k..16k+15), back-to-back with out_ready=1 -> every byte matches the FIPS-197 forward S-box. Bench also round-trips each byte through its inverse-table model and recovers the input.
